// File: rtl/rf_bypass_param.sv
// Parametrised 2-read / 1-write register file with write-to-read bypass,
// optional hardwired zero register, optional registered read and range error.
module rf_bypass_param #(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,
    parameter bit READ_REG = 1'b0,
    parameter bit ZERO_REG = 1'b0,
    localparam int ADDR_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1regsel,
    input  logic [ADDR_W-1:0] read2regsel,
    input  logic [ADDR_W-1:0] writeregsel,
    input  logic [DATA_W-1:0] writedata,
    input  logic              write,
    output logic [DATA_W-1:0] read1data,
    output logic [DATA_W-1:0] read2data,
    output logic              err
);

    // NREG need not be a power of two, so a select can name a register that does not exist.
    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return 32'(sel) < 32'(NREG);
    endfunction

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] rsel [2];
    logic [DATA_W-1:0] rval [2];
    logic              wr_valid;
    logic              rerr;
    logic [DATA_W-1:0] rd1_out, rd2_out;
    logic              err_out;

    assign rsel[0]  = read1regsel;
    assign rsel[1]  = read2regsel;
    assign wr_valid = write && in_range(writeregsel) && !(ZERO_REG && writeregsel == '0);
    assign rerr     = (write && !in_range(writeregsel))
                    || !in_range(read1regsel) || !in_range(read2regsel);

    // NOTE: the storage is plain flops, not a RAM macro, so clearing every entry on reset is legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_valid) begin
            // Decoded loop keeps every index inside the array even for odd NREG.
            for (int i = 0; i < NREG; i++) begin
                if (writeregsel == ADDR_W'(i)) regs[i] <= writedata;
            end
        end
    end

    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rval[p] = '0;
            if (in_range(rsel[p]) && !(ZERO_REG && rsel[p] == '0)) begin
                if (wr_valid && writeregsel == rsel[p]) begin
                    rval[p] = writedata;
                end else begin
                    for (int i = 0; i < NREG; i++) begin
                        if (rsel[p] == ADDR_W'(i)) rval[p] = regs[i];
                    end
                end
            end
        end
    end

    generate
        if (READ_REG) begin : g_reg_read
            logic [DATA_W-1:0] q1, q2;
            logic              qerr;

            // NOTE: sequential state uses non-blocking assignment so all flops sample together.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q1   <= '0;
                    q2   <= '0;
                    qerr <= 1'b0;
                end else begin
                    q1   <= rval[0];
                    q2   <= rval[1];
                    qerr <= rerr;
                end
            end

            assign rd1_out = q1;
            assign rd2_out = q2;
            assign err_out = qerr;
        end else begin : g_comb_read
            assign rd1_out = rval[0];
            assign rd2_out = rval[1];
            assign err_out = rerr;
        end
    endgenerate

    // Outputs read as zero for the whole reset cycle in either mode.
    assign read1data = rst ? '0 : rd1_out;
    assign read2data = rst ? '0 : rd2_out;
    assign err       = !rst && err_out;

endmodule
